interconn_sched: RTL

Burst-level scheduler for the MVU crossbar. Each MVU sender requests exclusive use of one destination port for a burst of words, and the scheduler grants ownership with round-robin fairness per destination. It drives the crossbar's per-destination source-select (`recv_from`) and provides a receive-valid mask, so receivers ignore words from senders that do not own their port. It sits beside the crossbar and shares its clock.

---
 rtl/interconn_pkg.sv | 20 ++
 rtl/interconn_sched_rr_arbiter.sv | 33 +++
 rtl/interconn_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/interconn_pkg.sv
// Shared types and defaults for the MVU crossbar burst scheduler.
// The watchdog is enabled by the INTERCONN_SCHED_TIMEOUT_EN macro.
package interconn_pkg;

  // Index width for an n-entry set. A single entry still needs a 1-bit index.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_DEF   = 8;
  localparam int A       = addr_w(N_DEF);
  localparam int LW_DEF  = 8;
  localparam int TMO_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

endpackage

// File: rtl/interconn_sched_rr_arbiter.sv
// N-way round-robin arbiter. The search starts at ptr, so ptr has the highest priority.
module rr_arbiter
  import interconn_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int A = addr_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [A-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [A-1:0] idx
);

  always_comb begin
    int unsigned pos;
    logic        found;
    // NOTE: every always_comb output gets a default before any branch.
    // A path that leaves an output unassigned would infer a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = A'(pos);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interconn_sched.sv
// Burst-level scheduler for the MVU crossbar. Each destination has round-robin ownership.
// If INTERCONN_SCHED_TIMEOUT_EN is defined, an idle-owner watchdog aborts stalled bursts.
module interconn_sched
  import interconn_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int LW  = LW_DEF,
  parameter  int TMO = TMO_DEF,
  localparam int A   = addr_w(N)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    req,
  input  logic [N*A-1:0]  req_dst,
  input  logic [N*LW-1:0] req_len,
  input  logic [N-1:0]    send_en,
  output logic [N-1:0]    gnt,
  output logic [N*A-1:0]  recv_from,
  output logic [N-1:0]    dst_active,
  output logic [N-1:0]    rx_mask,
  output logic [N-1:0]    tmo_err
);

  sched_state_t    state [N];
  logic [A-1:0]    own   [N];
  logic [A-1:0]    ptr   [N];
  logic [LW-1:0]   cnt   [N];

  logic [N*N-1:0]  elig;
  logic [N*N-1:0]  win_oh;
  logic [N*A-1:0]  win_idx;
  logic [N*LW-1:0] win_len;
  logic [N-1:0]    tmo_hit;

  always_comb begin
    gnt        = '0;
    dst_active = '0;
    recv_from  = '0;
    for (int j = 0; j < N; j++) begin
      recv_from[j*A +: A] = own[j];
      if (state[j] == BURST) begin
        gnt[own[j]]   = 1'b1;
        dst_active[j] = 1'b1;
      end
    end
  end

  // A sender that already owns a port is invisible to every arbiter.
  always_comb begin
    elig = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        elig[j*N + i] = req[i] && (req_dst[i*A +: A] == A'(j)) && !gnt[i];
  end

  for (genvar j = 0; j < N; j++) begin : g_arb
    rr_arbiter #(.N(N)) u_arb (
      .req (elig[j*N +: N]),
      .ptr (ptr[j]),
      .gnt (win_oh[j*N +: N]),
      .idx (win_idx[j*A +: A])
    );
  end

  always_comb begin
    logic [LW-1:0] wl;
    wl      = '0;
    win_len = '0;
    for (int j = 0; j < N; j++) begin
      wl = req_len[int'(win_idx[j*A +: A])*LW +: LW];
      win_len[j*LW +: LW] = (wl == '0) ? LW'(1) : wl;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // destination sees the same pre-edge values regardless of loop order.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the per-destination arrays are a few flops each, not RAM, so
      // they are reset like any other register.
      for (int j = 0; j < N; j++) begin
        state[j] <= IDLE;
        own[j]   <= '0;
        ptr[j]   <= '0;
        cnt[j]   <= '0;
      end
      rx_mask <= '0;
    end else begin
      rx_mask <= dst_active;
      for (int j = 0; j < N; j++) begin
        case (state[j])
          IDLE: begin
            if (|win_oh[j*N +: N]) begin
              state[j] <= BURST;
              own[j]   <= win_idx[j*A +: A];
              cnt[j]   <= win_len[j*LW +: LW];
            end
          end
          BURST: begin
            if (tmo_hit[j] || (send_en[own[j]] && cnt[j] == LW'(1))) begin
              state[j] <= IDLE;
              ptr[j]   <= (own[j] == A'(N-1)) ? '0 : own[j] + A'(1);
            end else if (send_en[own[j]]) begin
              cnt[j] <= cnt[j] - LW'(1);
            end
          end
          default: state[j] <= IDLE;
        endcase
      end
    end
  end

`ifdef INTERCONN_SCHED_TIMEOUT_EN
  localparam int TW = addr_w(TMO);
  logic [TW-1:0] idle_cnt [N];

  // The watchdog fires on the edge that would complete TMO cycles without an owner word.
  always_comb begin
    tmo_hit = '0;
    for (int j = 0; j < N; j++)
      tmo_hit[j] = (state[j] == BURST) && !send_en[own[j]] &&
                   (idle_cnt[j] == TW'(TMO - 1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < N; j++) idle_cnt[j] <= '0;
      tmo_err <= '0;
    end else begin
      tmo_err <= tmo_hit;
      for (int j = 0; j < N; j++) begin
        if (state[j] != BURST || send_en[own[j]] || tmo_hit[j])
          idle_cnt[j] <= '0;
        else
          idle_cnt[j] <= idle_cnt[j] + TW'(1);
      end
    end
  end
`else
  assign tmo_hit = '0;
  assign tmo_err = '0;
`endif

endmodule
